// File: rtl/ad_serial_rx.sv
// Purpose: serial ADC frame receiver (cs_n/sclk/sdata master) with an fx-bus register file.
// Latency: one frame is 34*(DIV+1) clk_sys cycles; ad_vld on HOLD entry; fx_q one cycle after fx_rd.
// Backpressure: none; a trigger arriving while a frame is in flight is dropped and flagged as overrun.
module ad_serial_rx (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [5:0]  dev_id,
    output logic        cs_n,
    output logic        sclk,
    input  logic        sdata,
    output logic [15:0] ad_data,
    output logic        ad_vld,
    input  logic [21:0] fx_waddr,
    input  logic        fx_wr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [21:0] fx_raddr,
    output logic [7:0]  fx_q
);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_DIV    = 8'h01;
    localparam logic [7:0] OFF_PER_L  = 8'h02;
    localparam logic [7:0] OFF_PER_H  = 8'h03;
    localparam logic [7:0] OFF_DATA_L = 8'h04;
    localparam logic [7:0] OFF_DATA_H = 8'h05;
    localparam logic [7:0] OFF_CNT    = 8'h06;
    localparam logic [7:0] OFF_STAT   = 8'h07;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // register file
    logic        ctrl_en_q, ctrl_en_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] per_q, per_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  fx_q_q, fx_q_d;

    // period counter
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] per_m1;
    logic        trig;

    // frame engine
    state_t      state_q, state_d;
    logic [7:0]  div_sh_q, div_sh_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [3:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [15:0] shift_q, shift_d;
    logic        sdata_q;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic [15:0] ad_data_q, ad_data_d;
    logic        ad_vld_q, ad_vld_d;

    logic        wr_hit, rd_hit;
    logic [7:0]  wr_off, rd_off;
    logic        tmr_done;
    logic        accept;
    logic        ovr_set, ovr_clr;
    logic        busy;

    assign wr_hit   = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rd_hit   = fx_rd && (fx_raddr[21:16] == dev_id);
    assign wr_off   = fx_waddr[7:0];
    assign rd_off   = fx_raddr[7:0];
    assign tmr_done = (tmr_q == div_sh_q);
    assign busy     = (state_q != IDLE);

    // Writable configuration; ro offsets and foreign device ids fall through untouched
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        div_d     = div_q;
        per_d     = per_q;
        if (wr_hit) begin
            case (wr_off)
                OFF_CTRL:  ctrl_en_d   = fx_data[0];
                OFF_DIV:   div_d       = fx_data;
                OFF_PER_L: per_d[7:0]  = fx_data;
                OFF_PER_H: per_d[15:8] = fx_data;
                default:   ;
            endcase
        end
    end

    // Period counter: free-runs 0..PER-1 while enabled, PER=0 behaves as PER=1.
    // It is cleared on the same edge that disable lands so a re-enable starts a fresh period.
    always_comb begin
        per_m1    = (per_q == 16'd0) ? 16'd0 : (per_q - 16'd1);
        trig      = ctrl_en_q && ctrl_en_d && (per_cnt_q >= per_m1);
        per_cnt_d = 16'd0;
        if (ctrl_en_q && ctrl_en_d && (per_cnt_q < per_m1)) begin
            per_cnt_d = per_cnt_q + 16'd1;
        end
    end

    // A trigger is taken in IDLE, or on the final HOLD cycle so PER == frame length runs back-to-back
    assign accept  = trig && ((state_q == IDLE) || ((state_q == HOLD) && tmr_done));
    assign ovr_set = trig && !accept;
    assign ovr_clr = wr_hit && (wr_off == OFF_STAT) && fx_data[0];

    // Sticky overrun; a same-cycle set beats the write-1 clear
    always_comb begin
        ovr_d = ovr_set | (ovr_q & ~ovr_clr);
    end

    // Frame FSM next-state and registered output values
    always_comb begin
        state_d   = state_q;
        div_sh_d  = div_sh_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        ad_data_d = ad_data_q;
        ad_vld_d  = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SETUP;
                    div_sh_d = div_q;
                    tmr_d    = 8'd0;
                    cs_n_d   = 1'b0;
                    sclk_d   = 1'b0;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_d = SHIFT;
                    tmr_d   = 8'd0;
                    phase_d = 1'b0;
                    bit_d   = 4'd0;
                    sclk_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!tmr_done) begin
                    tmr_d = tmr_q + 8'd1;
                end else begin
                    tmr_d = 8'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        // high->low transition: sample the registered serial input
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[14:0], sdata_q};
                        if (bit_q == 4'd15) begin
                            state_d   = HOLD;
                            cs_n_d    = 1'b1;
                            ad_data_d = {shift_q[14:0], sdata_q};
                            ad_vld_d  = 1'b1;
                            cnt_d     = cnt_q + 8'd1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    if (accept) begin
                        state_d  = SETUP;
                        div_sh_d = div_q;
                        tmr_d    = 8'd0;
                        cs_n_d   = 1'b0;
                        sclk_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tmr_d   = 8'd0;
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase

        // Disable aborts on the same edge the CTRL write lands; the partial frame is discarded
        if (!ctrl_en_d) begin
            state_d   = IDLE;
            tmr_d     = 8'd0;
            cs_n_d    = 1'b1;
            sclk_d    = 1'b0;
            ad_vld_d  = 1'b0;
            ad_data_d = ad_data_q;
            cnt_d     = cnt_q;
        end
    end

    // Registered read data, zero when no matching read
    always_comb begin
        fx_q_d = 8'h00;
        if (rd_hit) begin
            case (rd_off)
                OFF_CTRL:   fx_q_d = {7'd0, ctrl_en_q};
                OFF_DIV:    fx_q_d = div_q;
                OFF_PER_L:  fx_q_d = per_q[7:0];
                OFF_PER_H:  fx_q_d = per_q[15:8];
                OFF_DATA_L: fx_q_d = ad_data_q[7:0];
                OFF_DATA_H: fx_q_d = ad_data_q[15:8];
                OFF_CNT:    fx_q_d = cnt_q;
                OFF_STAT:   fx_q_d = {6'd0, busy, ovr_q};
                default:    fx_q_d = 8'h00;
            endcase
        end
    end

    // Register file and period counter state
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q <= 1'b0;
            div_q     <= 8'h03;
            per_q     <= 16'h03E8;
            cnt_q     <= 8'h00;
            ovr_q     <= 1'b0;
            fx_q_q    <= 8'h00;
            per_cnt_q <= 16'd0;
        end else begin
            ctrl_en_q <= ctrl_en_d;
            div_q     <= div_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            fx_q_q    <= fx_q_d;
            per_cnt_q <= per_cnt_d;
        end
    end

    // Frame FSM state, serial input flop and ADC-facing outputs
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_sh_q  <= 8'd0;
            tmr_q     <= 8'd0;
            bit_q     <= 4'd0;
            phase_q   <= 1'b0;
            shift_q   <= 16'd0;
            sdata_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            ad_data_q <= 16'd0;
            ad_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_sh_q  <= div_sh_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            sdata_q   <= sdata;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            ad_data_q <= ad_data_d;
            ad_vld_q  <= ad_vld_d;
        end
    end

    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign ad_data = ad_data_q;
    assign ad_vld  = ad_vld_q;
    assign fx_q    = fx_q_q;

endmodule

// File: tb/tb_ad_serial_rx.sv
// Bench for ad_serial_rx: ADC model serves words per frame, scoreboard checks ad_data on ad_vld.
// Expected words are queued at cs_n fall and dropped again if the frame does not complete.
// Register behaviour is checked with fx-bus reads against bench-side expectations.
module tb_ad_serial_rx;

    localparam logic [5:0] DEV = 6'h2A;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [5:0]  dev_id;
    logic        cs_n;
    logic        sclk;
    logic        sdata = 1'b0;
    logic [15:0] ad_data;
    logic        ad_vld;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;

    ad_serial_rx dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .dev_id   (dev_id),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .sdata    (sdata),
        .ad_data  (ad_data),
        .ad_vld   (ad_vld),
        .fx_waddr (fx_waddr),
        .fx_wr    (fx_wr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q)
    );

    always #5 clk_sys = ~clk_sys;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // reference model state
    logic [15:0] exp_q[$];
    logic [15:0] cur_word = 16'd0;
    logic [15:0] last_word = 16'd0;
    logic [15:0] force_word = 16'd0;
    bit          use_force = 1'b0;
    int          exp_cnt = 0;
    int          cfg_div = 3;
    int          cfg_gap = 0;
    bit          gap_chk = 1'b0;
    bit          have_fall = 1'b0;
    int          last_fall = 0;
    int          falls = 0;
    int          bit_idx = 0;
    int          frames_started = 0;
    int          frames_done = 0;
    int          vld_cnt = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_vld = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk_sys) cyc++;

    // ADC model: word MSB on cs_n fall, next bit after every sclk fall; frame bookkeeping
    always @(posedge clk_sys) begin
        #1;
        if (prev_sclk && !sclk) begin
            falls++;
            bit_idx--;
            sdata = (bit_idx >= 0) ? cur_word[bit_idx] : 1'b0;
        end
        if (prev_cs && !cs_n) begin
            cur_word = use_force ? force_word : 16'($urandom);
            exp_q.push_back(cur_word);
            falls = 0;
            bit_idx = 15;
            sdata = cur_word[15];
            frames_started++;
            if (gap_chk && have_fall) check("frame_gap", cyc - last_fall, cfg_gap);
            last_fall = cyc;
            have_fall = 1'b1;
        end
        if (!prev_cs && cs_n) begin
            if (falls == 16) begin
                check("cs_low_len", cyc - last_fall, 33 * (cfg_div + 1));
                exp_cnt = (exp_cnt + 1) % 256;
                last_word = cur_word;
                frames_done++;
            end else if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
            end
        end
        prev_cs = cs_n;
        prev_sclk = sclk;
    end

    // Scoreboard monitor
    always @(negedge clk_sys) begin
        if (ad_vld === 1'b1) begin
            vld_cnt++;
            check("ad_vld_single", {31'd0, prev_vld}, 32'd0);
            check("sb_has_expect", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) check("ad_data", {16'd0, ad_data}, {16'd0, exp_q.pop_front()});
        end
        prev_vld = ad_vld;
    end

    task automatic fx_write(input logic [5:0] id, input logic [7:0] off, input logic [7:0] d);
        fx_wr = 1'b1;
        fx_waddr = {id, 8'h00, off};
        fx_data = d;
        @(negedge clk_sys);
        fx_wr = 1'b0;
    endtask

    task automatic fx_read(input logic [5:0] id, input logic [7:0] mid, input logic [7:0] off,
                           output logic [7:0] q);
        fx_rd = 1'b1;
        fx_raddr = {id, mid, off};
        @(negedge clk_sys);
        q = fx_q;
        fx_rd = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] off, input logic [7:0] exp);
        logic [7:0] q;
        fx_read(DEV, 8'h00, off, q);
        check(nm, {24'd0, q}, {24'd0, exp});
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target;
        int k;
        target = frames_done + n;
        k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk_sys);
            k++;
        end
        check("wait_frames", (frames_done >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_cs_fall(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (cs_n !== 1'b0 && k < budget);
        check("wait_cs_fall", {31'd0, cs_n}, 32'd0);
    endtask

    task automatic configure(input int div, input int per, input int gap, input bit chk);
        fx_write(DEV, 8'h00, 8'h00);
        fx_write(DEV, 8'h01, 8'(div));
        fx_write(DEV, 8'h02, 8'(per));
        fx_write(DEV, 8'h03, 8'(per >> 8));
        cfg_div = div;
        cfg_gap = gap;
        gap_chk = chk;
        have_fall = 1'b0;
    endtask

    initial begin
        int rises;
        int k;
        int vld0;
        int started0;
        logic [7:0] q;
        logic [7:0] c0;
        logic       pv;

        rst_n = 1'b0;
        dev_id = DEV;
        fx_waddr = '0;
        fx_wr = 1'b0;
        fx_data = '0;
        fx_rd = 1'b0;
        fx_raddr = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_ad_data", {16'd0, ad_data}, 32'd0);
        check("rst_ad_vld", {31'd0, ad_vld}, 32'd0);
        check("rst_fx_q", {24'd0, fx_q}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        rd_chk("def_ctrl", 8'h00, 8'h00);
        rd_chk("def_div", 8'h01, 8'h03);
        rd_chk("def_per_l", 8'h02, 8'hE8);
        rd_chk("def_per_h", 8'h03, 8'h03);
        rd_chk("def_cnt", 8'h06, 8'h00);
        rd_chk("def_stat", 8'h07, 8'h00);
        repeat (1100) @(negedge clk_sys);
        check("no_frame_while_disabled", frames_started, 0);

        // defaults, fixed pattern 0xA55A, 1000-cycle trigger spacing, 136-cycle frames
        use_force = 1'b1;
        force_word = 16'hA55A;
        cfg_div = 3;
        cfg_gap = 1000;
        gap_chk = 1'b1;
        have_fall = 1'b0;
        fx_write(DEV, 8'h00, 8'h01);
        wait_frames(3, 4000);
        rd_chk("data_l_a55a", 8'h04, 8'h5A);
        rd_chk("data_h_a55a", 8'h05, 8'hA5);
        rd_chk("cnt_after3", 8'h06, 8'(exp_cnt));

        // DIV=0, PER=34: back-to-back frames, no overrun
        configure(0, 34, 34, 1'b1);
        force_word = 16'h8001;
        fx_write(DEV, 8'h00, 8'h01);
        wait_frames(10, 600);
        fx_write(DEV, 8'h00, 8'h00);
        rd_chk("stat_no_overrun", 8'h07, 8'h00);
        rd_chk("data_l_8001", 8'h04, 8'h01);
        rd_chk("data_h_8001", 8'h05, 8'h80);

        // PER=20, DIV=3: dropped triggers, set beats same-cycle clear
        use_force = 1'b0;
        configure(3, 20, 0, 1'b0);
        fx_write(DEV, 8'h00, 8'h01);
        wait_cs_fall(200);
        repeat (19) @(negedge clk_sys);
        fx_write(DEV, 8'h07, 8'h01);
        rd_chk("stat_busy_ovr", 8'h07, 8'h03);
        fx_write(DEV, 8'h00, 8'h00);
        rd_chk("stat_ovr_idle", 8'h07, 8'h01);
        fx_write(DEV, 8'h07, 8'h01);
        rd_chk("stat_cleared", 8'h07, 8'h00);

        // abort on 10th sclk rise
        configure(1, 200, 0, 1'b0);
        fx_write(DEV, 8'h00, 8'h01);
        wait_cs_fall(300);
        rises = 0;
        k = 0;
        pv = sclk;
        while (rises < 10 && k < 400) begin
            @(negedge clk_sys);
            if (sclk && !pv) rises++;
            pv = sclk;
            k++;
        end
        check("abort_rise10", rises, 10);
        vld0 = vld_cnt;
        fx_write(DEV, 8'h00, 8'h00);
        check("abort_cs_n", {31'd0, cs_n}, 32'd1);
        check("abort_sclk", {31'd0, sclk}, 32'd0);
        repeat (300) @(negedge clk_sys);
        check("abort_no_vld", vld_cnt, vld0);
        rd_chk("abort_cnt", 8'h06, 8'(exp_cnt));
        rd_chk("abort_data_l", 8'h04, last_word[7:0]);
        rd_chk("abort_data_h", 8'h05, last_word[15:8]);

        // 256 random frames: CNT wraps back to its start value
        configure(0, 34, 34, 1'b1);
        fx_read(DEV, 8'h00, 8'h06, c0);
        check("cnt_start", {24'd0, c0}, exp_cnt);
        fx_write(DEV, 8'h00, 8'h01);
        wait_frames(256, 256 * 34 + 300);
        fx_write(DEV, 8'h00, 8'h00);
        rd_chk("cnt_wrap", 8'h06, c0);
        rd_chk("wrap_data_l", 8'h04, last_word[7:0]);
        rd_chk("wrap_data_h", 8'h05, last_word[15:8]);
        rd_chk("data_l_reread", 8'h04, last_word[7:0]);
        fx_read(DEV ^ 6'h01, 8'h00, 8'h04, q);
        check("wrong_dev_read", {24'd0, q}, 32'd0);
        rd_chk("unmapped_read", 8'h08, 8'h00);
        fx_read(DEV, 8'hFF, 8'h01, q);
        check("mid_byte_ignored", {24'd0, q}, 32'd0);
        fx_write(DEV, 8'h06, 8'h55);
        rd_chk("cnt_ro", 8'h06, c0);
        fx_write(DEV ^ 6'h01, 8'h01, 8'h07);
        rd_chk("div_wrong_dev_wr", 8'h01, 8'h00);

        // reset mid-SHIFT takes effect asynchronously
        configure(3, 1000, 0, 1'b0);
        fx_write(DEV, 8'h00, 8'h01);
        wait_cs_fall(1200);
        repeat (40) @(negedge clk_sys);
        fx_rd = 1'b1;
        fx_raddr = {DEV, 8'h00, 8'h01};
        @(posedge clk_sys);
        #2;
        rst_n = 1'b0;
        exp_cnt = 0;
        last_word = 16'd0;
        #1;
        check("arst_cs_n", {31'd0, cs_n}, 32'd1);
        check("arst_sclk", {31'd0, sclk}, 32'd0);
        check("arst_ad_data", {16'd0, ad_data}, 32'd0);
        check("arst_ad_vld", {31'd0, ad_vld}, 32'd0);
        check("arst_fx_q", {24'd0, fx_q}, 32'd0);
        fx_rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        rd_chk("post_rst_ctrl", 8'h00, 8'h00);
        rd_chk("post_rst_cnt", 8'h06, 8'(exp_cnt));
        rd_chk("post_rst_data_h", 8'h05, last_word[15:8]);
        started0 = frames_started;
        repeat (1200) @(negedge clk_sys);
        check("no_frame_after_rst", frames_started, started0);

        check("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
